// File: rtl/rip_axi_interface_const.sv
// Shared AXI4 encodings used by every block that speaks rip_axi_interface.
package rip_axi_interface_const;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] SIZE_4B     = 3'd2;

endpackage

// File: rtl/rip_axi_interface.sv
// AXI4 bundle (AW/W/B/AR/R) with master and slave views.
interface rip_axi_interface #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ID_WIDTH-1:0]     AWID;
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic [7:0]              AWLEN;
    logic [2:0]              AWSIZE;
    logic [1:0]              AWBURST;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WLAST;
    logic                    WVALID;
    logic                    WREADY;
    logic [ID_WIDTH-1:0]     BID;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;
    logic [ID_WIDTH-1:0]     ARID;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic [7:0]              ARLEN;
    logic [2:0]              ARSIZE;
    logic [1:0]              ARBURST;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [ID_WIDTH-1:0]     RID;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RLAST;
    logic                    RVALID;
    logic                    RREADY;

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );
endinterface

// File: rtl/rip_block_ram_dp.sv
// Simple dual-port RAM: byte-enabled write port, registered read-first read port.
module rip_block_ram_dp #(
    parameter int WORDS      = 16384,
    parameter int ADDR_W     = 14,
    parameter int DATA_WIDTH = 32,
    parameter     INIT_FILE  = ""
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    re,
    input  logic [ADDR_W-1:0]       raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);
    logic [DATA_WIDTH-1:0] mem [WORDS];

    initial begin
        for (int i = 0; i < WORDS; i++) mem[i] = '0;
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < DATA_WIDTH/8; b++)
            if (we && wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
    end

    // Only the output register is reset; the array keeps its contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/rip_axi_slave_memory.sv
// AXI4 slave backed by block RAM; independent write and read FSMs, 32-bit beats only.
module rip_axi_slave_memory
    import rip_axi_interface_const::*;
#(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_BYTES  = 65536,
    parameter     INIT_FILE  = ""
) (
    input logic               clk,
    input logic               rst,
    rip_axi_interface.slave   S_AXI
);
    localparam int MEM_AW = $clog2(MEM_BYTES);
    localparam int WA     = MEM_AW - 2;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;

    w_state_e              w_state;
    logic                  awready_q, wready_q, bvalid_q;
    logic [ID_WIDTH-1:0]   bid_q, w_id;
    logic [1:0]            bresp_q, w_burst;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0]            w_len, w_beat;
    logic                  w_size_bad, w_err;

    r_state_e              r_state;
    logic                  arready_q, rvalid_q, rlast_q, r_err_q;
    logic [ID_WIDTH-1:0]   rid_q, r_id;
    logic [1:0]            rresp_q, r_burst;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len, r_beat;
    logic                  r_size_bad;

    logic [DATA_WIDTH-1:0] ram_q;
    logic                  w_hs, w_beat_err, w_last_err, r_beat_err;
    logic                  unused_addr_lsbs;

    assign w_hs       = S_AXI.WVALID && wready_q;
    assign w_beat_err = (w_burst == BURST_WRAP) || w_size_bad || (|w_addr[ADDR_WIDTH-1:MEM_AW]);
    assign w_last_err = S_AXI.WLAST != (w_beat == w_len);
    assign r_beat_err = (r_burst == BURST_WRAP) || r_size_bad || (|r_addr[ADDR_WIDTH-1:MEM_AW]);
    assign unused_addr_lsbs = ^{w_addr[1:0], r_addr[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state    <= W_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bid_q      <= '0;
            bresp_q    <= RESP_OKAY;
            w_id       <= '0;
            w_addr     <= '0;
            w_len      <= '0;
            w_burst    <= BURST_FIXED;
            w_size_bad <= 1'b0;
            w_err      <= 1'b0;
            w_beat     <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (S_AXI.AWVALID && awready_q) begin
                        w_id       <= S_AXI.AWID;
                        w_addr     <= S_AXI.AWADDR;
                        w_len      <= S_AXI.AWLEN;
                        w_burst    <= S_AXI.AWBURST;
                        w_size_bad <= S_AXI.AWSIZE != SIZE_4B;
                        w_err      <= 1'b0;
                        w_beat     <= '0;
                        awready_q  <= 1'b0;
                        wready_q   <= 1'b1;
                        w_state    <= W_DATA;
                    end
                end
                W_DATA: if (w_hs) begin
                    if (w_beat_err || w_last_err) w_err <= 1'b1;
                    if (w_burst == BURST_INCR) w_addr <= w_addr + ADDR_WIDTH'(4);
                    if (w_beat != w_len) w_beat <= w_beat + 8'd1;
                    // A burst can only end on WLAST, even if it arrives at the wrong beat.
                    if (S_AXI.WLAST) begin
                        wready_q <= 1'b0;
                        bvalid_q <= 1'b1;
                        bid_q    <= w_id;
                        bresp_q  <= (w_err || w_beat_err || w_last_err) ? RESP_SLVERR : RESP_OKAY;
                        w_state  <= W_RESP;
                    end
                end
                W_RESP: if (S_AXI.BREADY) begin
                    bvalid_q  <= 1'b0;
                    awready_q <= 1'b1;
                    w_state   <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            r_err_q    <= 1'b0;
            rid_q      <= '0;
            rresp_q    <= RESP_OKAY;
            r_id       <= '0;
            r_addr     <= '0;
            r_len      <= '0;
            r_burst    <= BURST_FIXED;
            r_size_bad <= 1'b0;
            r_beat     <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (S_AXI.ARVALID && arready_q) begin
                        r_id       <= S_AXI.ARID;
                        r_addr     <= S_AXI.ARADDR;
                        r_len      <= S_AXI.ARLEN;
                        r_burst    <= S_AXI.ARBURST;
                        r_size_bad <= S_AXI.ARSIZE != SIZE_4B;
                        r_beat     <= '0;
                        arready_q  <= 1'b0;
                        r_state    <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    rvalid_q <= 1'b1;
                    rlast_q  <= r_beat == r_len;
                    rid_q    <= r_id;
                    rresp_q  <= r_beat_err ? RESP_SLVERR : RESP_OKAY;
                    r_err_q  <= r_beat_err;
                    r_state  <= R_DATA;
                end
                R_DATA: if (S_AXI.RREADY) begin
                    rvalid_q <= 1'b0;
                    rlast_q  <= 1'b0;
                    if (rlast_q) begin
                        arready_q <= 1'b1;
                        r_state   <= R_IDLE;
                    end else begin
                        if (r_burst == BURST_INCR) r_addr <= r_addr + ADDR_WIDTH'(4);
                        if (r_beat != r_len) r_beat <= r_beat + 8'd1;
                        r_state <= R_FETCH;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    rip_block_ram_dp #(
        .WORDS      (MEM_BYTES / 4),
        .ADDR_W     (WA),
        .DATA_WIDTH (DATA_WIDTH),
        .INIT_FILE  (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (w_hs && !w_beat_err),
        .waddr (w_addr[MEM_AW-1:2]),
        .wdata (S_AXI.WDATA),
        .wstrb (S_AXI.WSTRB),
        .re    (r_state == R_FETCH),
        .raddr (r_addr[MEM_AW-1:2]),
        .rdata (ram_q)
    );

    assign S_AXI.AWREADY = awready_q;
    assign S_AXI.WREADY  = wready_q;
    assign S_AXI.BVALID  = bvalid_q;
    assign S_AXI.BID     = bid_q;
    assign S_AXI.BRESP   = bresp_q;
    assign S_AXI.ARREADY = arready_q;
    assign S_AXI.RVALID  = rvalid_q;
    assign S_AXI.RLAST   = rlast_q;
    assign S_AXI.RID     = rid_q;
    assign S_AXI.RRESP   = rresp_q;
    assign S_AXI.RDATA   = r_err_q ? '0 : ram_q;
endmodule

// File: tb/tb_rip_axi_slave_memory.sv
// Directed bench for rip_axi_slave_memory: writes, strobes, bursts, errors, concurrency, reset.
module tb_rip_axi_slave_memory;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    rip_axi_interface #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

    rip_axi_slave_memory #(
        .ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_BYTES(65536), .INIT_FILE("")
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .S_AXI (axi)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // All helpers start and end just after a falling edge.
    task automatic do_aw(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst,
                         input logic [2:0] size);
        int n = 0;
        axi.AWID = 4'h3; axi.AWADDR = a; axi.AWLEN = len; axi.AWBURST = burst;
        axi.AWSIZE = size; axi.AWVALID = 1'b1;
        while (!axi.AWREADY && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("aw_timeout", 32'(axi.AWREADY), 32'd1);
        @(negedge clk); axi.AWVALID = 1'b0;
    endtask

    task automatic do_w(input logic [31:0] d, input logic [3:0] strb, input logic last);
        int n = 0;
        axi.WDATA = d; axi.WSTRB = strb; axi.WLAST = last; axi.WVALID = 1'b1;
        while (!axi.WREADY && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("w_timeout", 32'(axi.WREADY), 32'd1);
        @(negedge clk); axi.WVALID = 1'b0; axi.WLAST = 1'b0;
    endtask

    task automatic do_b(input string tag, input logic [1:0] resp);
        int n = 0;
        axi.BREADY = 1'b1;
        while (!axi.BVALID && n < 50) begin @(negedge clk); n++; end
        chk({tag, "_bvalid"}, 32'(axi.BVALID), 32'd1);
        chk({tag, "_bresp"}, 32'(axi.BRESP), 32'(resp));
        chk({tag, "_bid"}, 32'(axi.BID), 32'h3);
        @(negedge clk); axi.BREADY = 1'b0;
    endtask

    task automatic do_ar(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst);
        int n = 0;
        axi.ARID = 4'h5; axi.ARADDR = a; axi.ARLEN = len; axi.ARBURST = burst;
        axi.ARSIZE = 3'd2; axi.ARVALID = 1'b1;
        while (!axi.ARREADY && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("ar_timeout", 32'(axi.ARREADY), 32'd1);
        @(negedge clk); axi.ARVALID = 1'b0;
    endtask

    task automatic do_r(input string tag, input logic [31:0] d, input logic [1:0] resp,
                        input logic last);
        int n = 0;
        while (!axi.RVALID && n < 50) begin @(negedge clk); n++; end
        chk({tag, "_rvalid"}, 32'(axi.RVALID), 32'd1);
        chk({tag, "_rdata"}, axi.RDATA, d);
        chk({tag, "_rresp"}, 32'(axi.RRESP), 32'(resp));
        chk({tag, "_rlast"}, 32'(axi.RLAST), 32'(last));
        chk({tag, "_rid"}, 32'(axi.RID), 32'h5);
        axi.RREADY = 1'b1;
        @(negedge clk); axi.RREADY = 1'b0;
    endtask

    task automatic write1(input logic [31:0] a, input logic [31:0] d, input logic [3:0] strb,
                          input string tag);
        do_aw(a, 8'd0, 2'b01, 3'd2);
        do_w(d, strb, 1'b1);
        do_b(tag, 2'b00);
    endtask

    logic [31:0] burst_data [4];

    initial begin
        axi.AWVALID = 0; axi.AWID = 0; axi.AWADDR = 0; axi.AWLEN = 0; axi.AWSIZE = 0; axi.AWBURST = 0;
        axi.WVALID = 0; axi.WDATA = 0; axi.WSTRB = 0; axi.WLAST = 0; axi.BREADY = 0;
        axi.ARVALID = 0; axi.ARID = 0; axi.ARADDR = 0; axi.ARLEN = 0; axi.ARSIZE = 0; axi.ARBURST = 0;
        axi.RREADY = 0;
        burst_data[0] = 32'haaaaaaaa; burst_data[1] = 32'hbbbbbbbb;
        burst_data[2] = 32'hcccccccc; burst_data[3] = 32'hdddddddd;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_awready", 32'(axi.AWREADY), 32'd0);
        chk("rst_arready", 32'(axi.ARREADY), 32'd0);
        chk("rst_wready", 32'(axi.WREADY), 32'd0);
        chk("rst_bvalid", 32'(axi.BVALID), 32'd0);
        chk("rst_rvalid", 32'(axi.RVALID), 32'd0);
        chk("rst_rlast", 32'(axi.RLAST), 32'd0);
        chk("rst_rdata", axi.RDATA, 32'd0);
        chk("rst_bresp", 32'(axi.BRESP), 32'd0);
        rst = 1'b0;
        chk("rel_awready_pre", 32'(axi.AWREADY), 32'd0);
        @(negedge clk);
        chk("rel_awready", 32'(axi.AWREADY), 32'd1);
        chk("rel_arready", 32'(axi.ARREADY), 32'd1);

        // Single write then read, with B and R latency
        do_aw(32'h4, 8'd0, 2'b01, 3'd2);
        do_w(32'h89abcdef, 4'b1111, 1'b1);
        chk("single_b_lat", 32'(axi.BVALID), 32'd1);
        do_b("single", 2'b00);
        do_ar(32'h4, 8'd0, 2'b01);
        chk("single_r_lat1", 32'(axi.RVALID), 32'd0);
        @(negedge clk);
        chk("single_r_lat2", 32'(axi.RVALID), 32'd1);
        do_r("single", 32'h89abcdef, 2'b00, 1'b1);

        // Strobe merge: bytes 3 and 1 taken from the second write
        write1(32'h10, 32'hdecafe10, 4'b1111, "strb_a");
        write1(32'h10, 32'h01234567, 4'b1010, "strb_b");
        do_ar(32'h10, 8'd0, 2'b01);
        do_r("strb", 32'h01ca4510, 2'b00, 1'b0 | 1'b1);

        // INCR burst, read back with RREADY stalled a cycle per beat
        do_aw(32'h20, 8'd3, 2'b01, 3'd2);
        for (int i = 0; i < 4; i++) do_w(burst_data[i], 4'b1111, i == 3);
        do_b("incr", 2'b00);
        do_ar(32'h20, 8'd3, 2'b01);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("incr_stall_data", axi.RDATA, burst_data[i]);
            @(negedge clk);
            chk("incr_stall_valid", 32'(axi.RVALID), 32'd1);
            do_r("incr", burst_data[i], 2'b00, i == 3);
        end

        // Errors
        do_ar(32'h10000, 8'd0, 2'b01);
        do_r("oor", 32'h0, 2'b10, 1'b1);
        do_aw(32'h4, 8'd0, 2'b10, 3'd2);
        do_w(32'h12345678, 4'b1111, 1'b1);
        do_b("wrap", 2'b10);
        do_ar(32'h4, 8'd0, 2'b01);
        do_r("wrap_mem", 32'h89abcdef, 2'b00, 1'b1);
        do_aw(32'h50, 8'd3, 2'b01, 3'd2);
        do_w(32'h11111111, 4'b1111, 1'b0);
        do_w(32'h22222222, 4'b1111, 1'b1);
        do_b("early_last", 2'b10);

        // Concurrent write and read of the same word: read sees old data
        write1(32'h40, 32'hcccccccc, 4'b1111, "conc_pre");
        axi.AWID = 4'h3; axi.AWADDR = 32'h40; axi.AWLEN = 0; axi.AWBURST = 2'b01; axi.AWSIZE = 3'd2;
        axi.ARID = 4'h5; axi.ARADDR = 32'h40; axi.ARLEN = 0; axi.ARBURST = 2'b01; axi.ARSIZE = 3'd2;
        axi.WDATA = 32'hffffffff; axi.WSTRB = 4'b1111; axi.WLAST = 1'b1;
        axi.AWVALID = 1'b1; axi.ARVALID = 1'b1; axi.WVALID = 1'b1;
        @(negedge clk);
        axi.AWVALID = 1'b0; axi.ARVALID = 1'b0;
        @(negedge clk);
        axi.WVALID = 1'b0; axi.WLAST = 1'b0;
        chk("conc_bvalid", 32'(axi.BVALID), 32'd1);
        chk("conc_rvalid", 32'(axi.RVALID), 32'd1);
        chk("conc_rdata", axi.RDATA, 32'hcccccccc);
        chk("conc_bresp", 32'(axi.BRESP), 32'd0);
        axi.BREADY = 1'b1; axi.RREADY = 1'b1;
        @(negedge clk);
        axi.BREADY = 1'b0; axi.RREADY = 1'b0;
        do_ar(32'h40, 8'd0, 2'b01);
        do_r("conc_new", 32'hffffffff, 2'b00, 1'b1);

        // Reset in the middle of a read burst
        do_ar(32'h20, 8'd7, 2'b01);
        do_r("mid_b0", 32'haaaaaaaa, 2'b00, 1'b0);
        do_r("mid_b1", 32'hbbbbbbbb, 2'b00, 1'b0);
        @(negedge clk);
        chk("mid_b2_valid", 32'(axi.RVALID), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rvalid_async", 32'(axi.RVALID), 32'd0);
        chk("mid_rdata_async", axi.RDATA, 32'd0);
        repeat (2) @(negedge clk);
        chk("mid_arready_rst", 32'(axi.ARREADY), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_arready_rel", 32'(axi.ARREADY), 32'd1);
        chk("mid_rvalid_rel", 32'(axi.RVALID), 32'd0);
        do_ar(32'h20, 8'd0, 2'b01);
        do_r("mid_mem20", 32'haaaaaaaa, 2'b00, 1'b1);
        do_ar(32'h4, 8'd0, 2'b01);
        do_r("mid_mem4", 32'h89abcdef, 2'b00, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
